mem_arbiter: RTL and testbench

- Shares one single-port synchronous word RAM among three requesters: CPU instruction fetch (read-only), CPU data port (read/write) and a program loader (read/write).
- Sits between CPU_Core's IMEM/DMEM address/data ports and a unified 1-cycle-latency RAM.
- Owns a run/load mode FSM that holds the core while the loader has the memory.
- Prevents fetch starvation under back-to-back data traffic.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_starve_ctr.sv | 30 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF         = 10;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 4;

  // Memory ownership mode
  typedef enum logic [1:0] {RUN, LOAD, DRAIN} arb_state_t;

  // Requester whose read data arrives on mem_rdata in the next cycle
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D, OWN_LD} owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a waiting fetch was denied.
module mem_arb_starve_ctr #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] cnt;

  // Clear wins over increment; the count holds once it reaches MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_W)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_max = (cnt == MAX_W);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port 1-cycle-latency RAM between instruction fetch,
// CPU data port and a program loader, with a run/load ownership FSM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          ld_en,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_hold
);

  arb_state_t state, state_next;
  owner_t     rd_owner, rd_owner_next;
  logic       hold_next;
  logic       starve_at_max;
  logic       starve_clr;
  logic       starve_inc;

  // Fetch is cleared whenever it is served, absent, or the CPU is locked out
  assign starve_clr = (state != RUN) || !if_req || if_gnt;
  assign starve_inc = if_req && !if_gnt;

  mem_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (CLK),
    .rst_n  (RSTn),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .at_max (starve_at_max)
  );

  // Next state, hold request and grant selection; no grants while in reset
  always_comb begin
    state_next = state;
    hold_next  = cpu_hold;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    ld_gnt     = 1'b0;
    case (state)
      RUN: begin
        if (if_req && d_req) begin
          if (starve_at_max) if_gnt = 1'b1;
          else               d_gnt  = 1'b1;
        end else begin
          if_gnt = if_req;
          d_gnt  = d_req;
        end
        if (ld_en) begin
          state_next = LOAD;
          hold_next  = 1'b1;
        end
      end
      LOAD: begin
        ld_gnt = ld_en && ld_req;
        if (!ld_en) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = RUN;
        hold_next  = 1'b0;
      end
      default: begin
        state_next = RUN;
        hold_next  = 1'b0;
      end
    endcase
    if (!RSTn) begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      ld_gnt = 1'b0;
    end
  end

  // RAM port mux from the single winner; also decides who owns the next read return
  always_comb begin
    mem_en        = if_gnt || d_gnt || ld_gnt;
    mem_we        = 1'b0;
    mem_addr      = d_addr;
    mem_wdata     = d_wdata;
    rd_owner_next = OWN_NONE;
    if (if_gnt) begin
      mem_addr      = if_addr;
      rd_owner_next = OWN_IF;
    end else if (d_gnt) begin
      mem_we = d_we;
      if (!d_we) rd_owner_next = OWN_D;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      mem_we    = ld_we;
      if (!ld_we) rd_owner_next = OWN_LD;
    end
  end

  // State, hold and read-owner registers; reset drops any read in flight
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RUN;
      cpu_hold <= 1'b0;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_next;
      cpu_hold <= hold_next;
      rd_owner <= rd_owner_next;
    end
  end

  assign if_rvalid = (rd_owner == OWN_IF);
  assign d_rvalid  = (rd_owner == OWN_D);
  assign ld_rvalid = (rd_owner == OWN_LD);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign ld_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// each cycle compared against a rule-level reference model.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          if_req, d_req, d_we, ld_en, ld_req, ld_we;
  logic [AW-1:0] if_addr, d_addr, ld_addr;
  logic [DW-1:0] d_wdata, ld_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, ld_gnt, ld_rvalid;
  logic [DW-1:0] if_rdata, d_rdata, ld_rdata;
  logic          mem_en, mem_we, cpu_hold;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0=run 1=load 2=drain; pend 0=none 1=if 2=d 3=ld
  int            m_mode   = 0;
  bit            m_hold   = 1'b0;
  int            m_starve = 0;
  int            m_pend   = 0;
  logic [DW-1:0] m_pdata;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] ram     [0:(1<<AW)-1];

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_en(ld_en), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_word(input int i);
    return (DW'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Environment RAM with one cycle of read latency
  initial for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hold = 1'b0; m_starve = 0; m_pend = 0;
  endtask

  // One clock cycle: check mid-cycle, optionally assert reset before the edge, advance model
  task automatic cycle(input bit rst_mid);
    bit            e_if, e_d, e_ld, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #4;
    e_if = 0; e_d = 0; e_ld = 0;
    if (RSTn) begin
      if (m_mode == 0) begin
        if (if_req && (!d_req || m_starve == SM)) e_if = 1;
        else if (d_req)                           e_d  = 1;
      end else if (m_mode == 1) begin
        e_ld = ld_en && ld_req;
      end
    end
    e_we   = e_d ? d_we : (e_ld ? ld_we : 1'b0);
    e_addr = e_if ? if_addr : (e_d ? d_addr : ld_addr);
    e_wd   = e_d ? d_wdata : ld_wdata;
    chk("if_gnt", if_gnt, e_if);
    chk("d_gnt", d_gnt, e_d);
    chk("ld_gnt", ld_gnt, e_ld);
    chk("mem_en", mem_en, e_if | e_d | e_ld);
    chk("mem_we", mem_we, e_we);
    if (e_if | e_d | e_ld) chk("mem_addr", mem_addr, e_addr);
    if (e_we)              chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_hold", cpu_hold, m_hold);
    chk("if_rvalid", if_rvalid, m_pend == 1);
    chk("d_rvalid", d_rvalid, m_pend == 2);
    chk("ld_rvalid", ld_rvalid, m_pend == 3);
    if (m_pend == 1) chk("if_rdata", if_rdata, m_pdata);
    if (m_pend == 2) chk("d_rdata", d_rdata, m_pdata);
    if (m_pend == 3) chk("ld_rdata", ld_rdata, m_pdata);
    if (rst_mid) begin
      #2;
      RSTn = 1'b0;
    end
    @(posedge CLK);
    if (!RSTn) begin
      model_reset();
    end else begin
      m_pend = 0;
      if (e_if) begin
        m_pend = 1; m_pdata = ref_mem[if_addr];
      end else if (e_d) begin
        if (d_we) ref_mem[d_addr] = d_wdata;
        else begin m_pend = 2; m_pdata = ref_mem[d_addr]; end
      end else if (e_ld) begin
        if (ld_we) ref_mem[ld_addr] = ld_wdata;
        else begin m_pend = 3; m_pdata = ref_mem[ld_addr]; end
      end
      if (m_mode == 0 && if_req && !e_if) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else                                m_starve = 0;
      case (m_mode)
        0: if (ld_en) begin m_mode = 1; m_hold = 1'b1; end
        1: if (!ld_en) m_mode = 2;
        default: begin m_mode = 0; m_hold = 1'b0; end
      endcase
    end
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; d_req = 0; d_we = 0; ld_en = 0; ld_req = 0; ld_we = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    model_reset();
    // Reset held with every request raised
    RSTn = 0; if_req = 1; d_req = 1; d_we = 0; ld_en = 0; ld_req = 1; ld_we = 0;
    if_addr = 10'h010; d_addr = 10'h020; ld_addr = 10'h030; d_wdata = '0; ld_wdata = '0;
    @(posedge CLK); #1;
    cycle(0); cycle(0);
    // Lone fetch after release
    RSTn = 1; idle_inputs(); if_req = 1; if_addr = 10'h010;
    cycle(0);
    idle_inputs();
    cycle(0);
    // Fetch/data conflict: data wins four times, then the starved fetch
    if_req = 1; d_req = 1; d_we = 0; d_addr = 10'h020;
    for (int i = 0; i < 15; i++) begin
      if_addr = AW'($urandom);
      cycle(0);
    end
    idle_inputs();
    cycle(0);
    // Data write to the top address, then fetch it back
    d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
    cycle(0);
    idle_inputs(); if_req = 1; if_addr = 10'h3FF;
    cycle(0);
    chk("fetch_3ff_data", if_rdata, 32'hDEAD_BEEF);
    idle_inputs();
    cycle(0);
    // Load sequence with the fetch still requesting
    ld_en = 1; if_req = 1; if_addr = 10'h005;
    cycle(0);
    ld_req = 1; ld_we = 1; ld_addr = 10'h000; ld_wdata = 32'hA5A5_A5A5;
    cycle(0);
    ld_we = 0;
    cycle(0);
    ld_en = 0; ld_req = 0;
    chk("ld_rvalid_final", ld_rvalid, 1'b1);
    chk("ld_rdata_final", ld_rdata, 32'hA5A5_A5A5);
    cycle(0); cycle(0); cycle(0);
    // Reset while a data read is outstanding
    idle_inputs(); d_req = 1; d_we = 0; d_addr = 10'h055;
    cycle(1);
    idle_inputs();
    cycle(0);
    RSTn = 1;
    cycle(0);
    // Idle, then confirm the starvation count restarted from zero
    for (int i = 0; i < 10; i++) cycle(0);
    if_req = 1; d_req = 1; d_we = 0; d_addr = 10'h020;
    for (int i = 0; i < 6; i++) cycle(0);
    // Random traffic with occasional load windows
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if_req = 1'($urandom_range(0, 1)); if_addr = AW'($urandom_range(0, 15));
      d_req  = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
      d_addr = AW'($urandom_range(0, 15)); d_wdata = $urandom;
      ld_req = 1'($urandom_range(0, 1)); ld_we = 1'($urandom_range(0, 1));
      ld_addr = AW'($urandom_range(0, 15)); ld_wdata = $urandom;
      if ($urandom_range(0, 19) == 0) ld_en = ~ld_en;
      cycle(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
